uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive-side byte buffer. Sits directly downstream of the UART receiver and consumes its `rdy`/`data` outputs.
- The receiver holds `rdy` high from frame completion until the next start bit. Its `data` register keeps shifting during reception.
- This block captures exactly one byte per completed frame, on the rising edge of `rdy`. It buffers bytes in a FIFO and presents them to the consumer through a valid/ready handshake.
- It also reports fill level and a sticky overflow flag.

Parameters:
- DEPTH, 8, number of byte entries; power of two, minimum 2.
- ADDR_W, 3, pointer width; equals log2(DEPTH).
- DATA_W, 8, byte width; matches the receiver data width.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rx_rdy  input  1  receiver `rdy`; level signal, high while a completed byte is held.
- rx_data  input  DATA_W  receiver `data`; valid in the cycle `rx_rdy` is high.
- out_valid  output  1  head entry available; equals not empty.
- out_ready  input  1  consumer accepts the head entry this cycle.
- out_data  output  DATA_W  head entry; first-word fall-through, combinational from memory at the read pointer.
- count  output  ADDR_W+1  number of stored entries, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky; a completed byte was dropped because the FIFO was full.
- clr_overflow  input  1  synchronous clear of `overflow`.

Behaviour:
- Reset (rst_n low, immediate, no clock required):
  - wr_ptr = 0, rd_ptr = 0, count = 0, overflow = 0, rdy_q = 1.
  - Outputs: out_valid = 0, empty = 1, full = 0.
  - Memory contents are not reset; out_data is don't-care while empty.
- Edge detect:
  - rdy_q <= rx_rdy every cycle.
  - push_req = rx_rdy & ~rdy_q, which is a single-cycle pulse per frame.
  - A level of rx_rdy that is already high at reset release is not captured, because rdy_q resets to 1.
  - A push requires a genuine 0->1 transition of rx_rdy.
- Pop: pop = out_valid & out_ready. When empty, out_ready is ignored.
- Push handling:
  - push = push_req & (~full | pop).
  - On push: mem[wr_ptr] <= rx_data, and wr_ptr increments modulo DEPTH.
- Pop handling: on pop, rd_ptr increments modulo DEPTH.
- Count update:
  - push only: count +1.
  - pop only: count -1.
  - both or neither: count unchanged.
- Latency:
  - A byte is sampled at the first clock edge where rx_rdy = 1 and rdy_q = 0.
  - out_valid and out_data reflect it immediately after that edge (1-cycle latency when empty).
- Full boundary:
  - push_req with full and no pop: byte dropped, pointers and count unchanged, overflow <= 1.
  - push_req with full and pop in the same cycle: push accepted, count stays DEPTH, and the new byte becomes the tail.
- Empty boundary: push_req with empty: accepted normally. No pop can occur that cycle, since out_valid = 0.
- Overflow flag:
  - Remains set until clr_overflow is high at a clock edge.
  - A drop event in the same cycle as clr_overflow takes precedence: overflow stays 1.
- Ordering and wrap:
  - Strict FIFO order is preserved across pointer wrap.
  - full and empty are derived from count, not from pointer compare.
- Reset mid-operation: all stored entries are discarded immediately. A frame in progress at the receiver is captured normally if its rdy edge arrives after rst_n deasserts.

Test Plan:
1. Hold rx_rdy = 1 through reset release, then 10 cycles idle -> count = 0, empty = 1, out_valid = 0, overflow = 0. Drive rx_rdy low then high with rx_data = 8'hE0 -> one edge later count = 1, out_data = 8'hE0.
2. Single frame: rx_rdy 0->1 with rx_data = 8'hC1, held high 6 cycles -> exactly one entry (count = 1). out_ready pulsed 1 cycle -> count = 0, empty = 1.
3. Fill: 8 rdy pulses with data 8'h01..8'h08, out_ready = 0 -> full = 1, count = 8. 9th pulse with 8'h09 -> dropped, overflow = 1. Drain -> 01..08 in order, then empty.
4. Full plus simultaneous pop: FIFO full with 01..08; rdy edge with 8'hAA and out_ready = 1 in the same cycle -> count stays 8. Drain order is 02..08, AA. Wrap occurs with no loss.
5. Overflow clear: clr_overflow with a concurrent drop event -> overflow remains 1. clr_overflow alone on a later cycle -> overflow = 0.
6. Async reset: 3 entries stored; assert rst_n low between clock edges -> count = 0, out_valid = 0, empty = 1 before the next edge. After release, a new edge with 8'h5A -> out_data = 8'h5A, count = 1.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer behind a UART receiver: captures one byte per rising
// edge of the receiver's rdy level and hands bytes out first-word fall-through.
module uart_rx_fifo #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx_rdy,
   input  logic [DATA_W-1:0] rx_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              empty,
   output logic              overflow,
   input  logic              clr_overflow
);

   // Handshake: a byte leaves when out_valid and out_ready are both high at a
   // rising clock edge; out_ready is ignored while out_valid is low.

   localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic              rdy_q;
   logic              push_req;
   logic              push;
   logic              pop;
   logic              drop;

   assign empty     = (count == '0);
   assign full      = (count == FULL_COUNT);
   assign out_valid = ~empty;
   assign out_data  = mem[rd_ptr];

   // rdy_q resets high so a level already present at reset release is ignored.
   assign push_req = rx_rdy & ~rdy_q;
   assign pop      = out_valid & out_ready;
   assign push     = push_req & (~full | pop);
   assign drop     = push_req & full & ~pop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         rdy_q    <= 1'b1;
      end else begin
         rdy_q <= rx_rdy;
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         if (push && !pop) begin
            count <= count + CNT_ONE;
         end else if (pop && !push) begin
            count <= count - CNT_ONE;
         end
         // A drop in the same cycle as a clear keeps the flag set.
         if (drop) begin
            overflow <= 1'b1;
         end else if (clr_overflow) begin
            overflow <= 1'b0;
         end
      end
   end

   // Storage is not reset; out_data is meaningless while empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= rx_data;
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed frames plus random traffic against a queue
// model; a monitor pops expected bytes whenever the DUT hands one out.
module tb_uart_rx_fifo;

   localparam int DEPTH  = 8;
   localparam int ADDR_W = 3;
   localparam int DATA_W = 8;

   logic              clk;
   logic              rst_n;
   logic              rx_rdy;
   logic [DATA_W-1:0] rx_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [ADDR_W:0]   count;
   logic              full;
   logic              empty;
   logic              overflow;
   logic              clr_overflow;

   int total = 0;
   int bad   = 0;

   logic [DATA_W-1:0] exp_q[$];

   int m_count = 0;
   bit m_prev  = 1'b1;
   bit m_ovf   = 1'b0;

   uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx_rdy       (rx_rdy),
      .rx_data      (rx_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .count        (count),
      .full         (full),
      .empty        (empty),
      .overflow     (overflow),
      .clr_overflow (clr_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int actual, input int expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference model: a byte count, the previous rdy level and a sticky flag,
   // evaluated at the falling edge for the rising edge that follows.
   always @(negedge clk) begin
      bit p_req;
      bit pop_e;
      bit acc;
      if (!rst_n) begin
         m_count = 0;
         m_prev  = 1'b1;
         m_ovf   = 1'b0;
         exp_q.delete();
      end else begin
         check("count", int'(count), m_count);
         check("full", int'(full), int'(m_count == DEPTH));
         check("empty", int'(empty), int'(m_count == 0));
         check("out_valid", int'(out_valid), int'(m_count != 0));
         check("overflow", int'(overflow), int'(m_ovf));
         p_req = rx_rdy && !m_prev;
         pop_e = (m_count > 0) && out_ready;
         acc   = p_req && ((m_count < DEPTH) || pop_e);
         if (acc) exp_q.push_back(rx_data);
         if (p_req && !acc) m_ovf = 1'b1;
         else if (clr_overflow) m_ovf = 1'b0;
         m_count = m_count + int'(acc) - int'(pop_e);
         m_prev  = rx_rdy;
      end
   end

   // Monitor: every accepted output byte must match the oldest expected byte.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_pop", 1, 0);
         end else begin
            check("out_data", int'(out_data), int'(exp_q.pop_front()));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One receiver frame: rdy low for lo cycles with shifting data, then high
   // with the final byte; pop/clr are applied on the capture edge.
   task automatic frame(input logic [DATA_W-1:0] d, input int lo, input int hold,
                        input logic pop, input logic clr);
      rx_rdy = 1'b0;
      for (int i = 0; i < lo; i++) begin
         rx_data = DATA_W'($urandom);
         tick();
      end
      rx_rdy       = 1'b1;
      rx_data      = d;
      out_ready    = pop;
      clr_overflow = clr;
      tick();
      out_ready    = 1'b0;
      clr_overflow = 1'b0;
      for (int i = 1; i < hold; i++) tick();
   endtask

   task automatic drain(input int n);
      out_ready = 1'b1;
      for (int i = 0; i < n; i++) tick();
      out_ready = 1'b0;
   endtask

   initial begin
      rst_n        = 1'b0;
      rx_rdy       = 1'b1;
      rx_data      = 8'h00;
      out_ready    = 1'b0;
      clr_overflow = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (10) tick();

      // rdy high through reset release is not a frame
      check("t1_count", int'(count), 0);
      check("t1_empty", int'(empty), 1);
      check("t1_valid", int'(out_valid), 0);
      check("t1_ovf", int'(overflow), 0);
      frame(8'hE0, 1, 1, 1'b0, 1'b0);
      check("t1_cnt_after", int'(count), 1);
      check("t1_data", int'(out_data), 'hE0);
      drain(1);

      // long rdy level gives exactly one entry
      frame(8'hC1, 2, 6, 1'b0, 1'b0);
      check("t2_count", int'(count), 1);
      check("t2_data", int'(out_data), 'hC1);
      drain(1);
      check("t2_empty", int'(empty), 1);

      // fill, drop, drain
      for (int i = 1; i <= DEPTH; i++) frame(DATA_W'(i), 1, 1, 1'b0, 1'b0);
      check("t3_full", int'(full), 1);
      check("t3_count", int'(count), DEPTH);
      frame(8'h09, 1, 1, 1'b0, 1'b0);
      check("t3_ovf", int'(overflow), 1);
      check("t3_count_drop", int'(count), DEPTH);
      check("t3_head", int'(out_data), 'h01);
      drain(DEPTH);
      check("t3_empty", int'(empty), 1);

      // full plus simultaneous pop
      for (int i = 1; i <= DEPTH; i++) frame(DATA_W'(i), 1, 1, 1'b0, 1'b0);
      frame(8'hAA, 1, 1, 1'b1, 1'b0);
      check("t4_count", int'(count), DEPTH);
      check("t4_head", int'(out_data), 'h02);
      drain(DEPTH);
      check("t4_empty", int'(empty), 1);

      // clear loses to a concurrent drop, then clears alone
      for (int i = 0; i < DEPTH; i++) frame(DATA_W'($urandom), 1, 1, 1'b0, 1'b0);
      frame(8'h77, 1, 1, 1'b0, 1'b1);
      check("t5_ovf_kept", int'(overflow), 1);
      clr_overflow = 1'b1;
      tick();
      clr_overflow = 1'b0;
      check("t5_ovf_clr", int'(overflow), 0);
      drain(DEPTH);

      // asynchronous reset between edges
      for (int i = 0; i < 3; i++) frame(DATA_W'($urandom), 1, 1, 1'b0, 1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_count", int'(count), 0);
      check("t6_valid", int'(out_valid), 0);
      check("t6_empty", int'(empty), 1);
      tick();
      rst_n = 1'b1;
      tick();
      frame(8'h5A, 1, 1, 1'b0, 1'b0);
      check("t6_data", int'(out_data), 'h5A);
      check("t6_count_after", int'(count), 1);

      // random traffic: frequent edges, varying consumer pressure
      for (int i = 0; i < 600; i++) begin
         rx_rdy       = ($urandom_range(0, 2) != 0);
         rx_data      = DATA_W'($urandom);
         out_ready    = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         clr_overflow = ($urandom_range(0, 15) == 0);
         tick();
      end
      rx_rdy       = 1'b1;
      clr_overflow = 1'b0;
      drain(DEPTH + 4);
      tick();
      check("final_queue", exp_q.size(), 0);
      check("final_empty", int'(empty), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
